// File: rtl/demux_pkg.sv
// Shared types and constants for the demux1to8_bank write-side register bank.
// Optional parity outputs are enabled by defining DEMUX_PARITY_EN.
package demux_pkg;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef logic [WIDTH-1:0] entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    // Even-parity bit of one entry: XOR of all data bits.
    function automatic logic evenParity(input entry_t value);
        return ^value;
    endfunction

endpackage

// File: rtl/wr_decoder3to8.sv
// 3-to-8 one-hot write-enable decoder; all outputs low when i_en is low.
module wr_decoder3to8
    import demux_pkg::*;
(
    input  logic [ADDR_W-1:0] i_sel,
    input  logic              i_en,
    output logic [DEPTH-1:0]  o_we
);

    // Raise exactly one enable bit, chosen by i_sel, when a write is happening.
    always_comb begin
        o_we = '0;
        if (i_en) begin
            o_we[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1to8_bank.sv
// demux1to8_bank: routes a 4-bit write into one of eight registered entries,
// either by single addressed writes or by an auto-incrementing 8-entry burst.
// Data width comes from demux_pkg::WIDTH.
// Define DEMUX_PARITY_EN to add the registered per-entry parity output.
module demux1to8_bank
    import demux_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  entry_t            i_din,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    output entry_t            o_dout0,
    output entry_t            o_dout1,
    output entry_t            o_dout2,
    output entry_t            o_dout3,
    output entry_t            o_dout4,
    output entry_t            o_dout5,
    output entry_t            o_dout6,
    output entry_t            o_dout7,
    output logic [DEPTH-1:0]  o_loaded,
    input  logic              i_clr,
    output logic              o_busy,
`ifdef DEMUX_PARITY_EN
    output logic [DEPTH-1:0]  o_parity,
`endif
    output logic              o_done
);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_nextPtr;
    logic [2:0]          r_cnt;
    logic [2:0]          w_nextCnt;
    logic                r_ready;
    entry_t              r_entry [DEPTH];
    logic [DEPTH-1:0]    r_loaded;
    logic                w_accept;
    logic                w_wrEn;
    logic [ADDR_W-1:0]   w_sel;
    logic [DEPTH-1:0]    w_we;
`ifdef DEMUX_PARITY_EN
    logic [DEPTH-1:0]    r_parity;
`endif

    // A write that collides with clr is discarded, so it neither lands nor advances the burst.
    assign w_accept = i_wr_valid && r_ready;
    assign w_wrEn   = w_accept && !i_clr;
    assign w_sel    = (r_state == FILL) ? r_ptr : i_addr;

    wr_decoder3to8 u_decoder (
        .i_sel (w_sel),
        .i_en  (w_wrEn),
        .o_we  (w_we)
    );

    // Next-state logic: IDLE starts a burst, FILL counts eight writes, DONE lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = FILL;
                    w_nextPtr   = i_start_addr;
                    w_nextCnt   = 3'd0;
                end
            end
            FILL: begin
                if (w_wrEn) begin
                    w_nextPtr = r_ptr + 3'd1;
                    w_nextCnt = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_nextState = DONE;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, burst pointer/count and registered ready; ready looks ahead so it is low during DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_cnt   <= w_nextCnt;
            r_ready <= (w_nextState != DONE);
        end
    end

    // Entry storage and loaded flags; clr wipes everything, otherwise only the enabled entry changes.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_loaded <= '0;
`ifdef DEMUX_PARITY_EN
            r_parity <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_entry[i]  <= i_din;
                    r_loaded[i] <= 1'b1;
`ifdef DEMUX_PARITY_EN
                    r_parity[i] <= evenParity(i_din);
`endif
                end
            end
        end
    end

    assign o_wr_ready = r_ready;
    assign o_busy     = (r_state == FILL);
    assign o_done     = (r_state == DONE);
    assign o_loaded   = r_loaded;
    assign o_dout0    = r_entry[0];
    assign o_dout1    = r_entry[1];
    assign o_dout2    = r_entry[2];
    assign o_dout3    = r_entry[3];
    assign o_dout4    = r_entry[4];
    assign o_dout5    = r_entry[5];
    assign o_dout6    = r_entry[6];
    assign o_dout7    = r_entry[7];
`ifdef DEMUX_PARITY_EN
    assign o_parity   = r_parity;
`endif

endmodule

// File: tb/tb_demux1to8_bank.sv
// Self-checking bench for demux1to8_bank: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the bank.
// Define DEMUX_PARITY_EN to also check the parity output.
module tb_demux1to8_bank;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrValid = 1'b0;
    logic       wrReady;
    logic [2:0] addr = 3'd0;
    logic [3:0] din = 4'd0;
    logic       start = 1'b0;
    logic [2:0] startAddr = 3'd0;
    logic       clr = 1'b0;
    logic [3:0] dout [8];
    logic [7:0] loaded;
    logic       busy;
    logic       done;
`ifdef DEMUX_PARITY_EN
    logic [7:0] parity;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: contents, loaded flags, burst bookkeeping.
    logic [3:0] mMem [8];
    logic [7:0] mLoaded = 8'h00;
    int         mMode = M_IDLE;
    int         mPtr = 0;
    int         mWritesLeft = 0;
    bit         mJustReset = 1'b1;
    int         donePulses = 0;

    // Clock generation, 10 time units per cycle.
    always #5 clk = ~clk;

    demux1to8_bank dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wrValid),
        .o_wr_ready   (wrReady),
        .i_addr       (addr),
        .i_din        (din),
        .i_start      (start),
        .i_start_addr (startAddr),
        .o_dout0      (dout[0]),
        .o_dout1      (dout[1]),
        .o_dout2      (dout[2]),
        .o_dout3      (dout[3]),
        .o_dout4      (dout[4]),
        .o_dout5      (dout[5]),
        .o_dout6      (dout[6]),
        .o_dout7      (dout[7]),
        .o_loaded     (loaded),
        .i_clr        (clr),
        .o_busy       (busy),
`ifdef DEMUX_PARITY_EN
        .o_parity     (parity),
`endif
        .o_done       (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit modelReady();
        return !mJustReset && (mMode != M_DONE);
    endfunction

    function automatic logic [31:0] packDut();
        logic [31:0] p;
        for (int i = 0; i < 8; i++) p[i*4 +: 4] = dout[i];
        return p;
    endfunction

    function automatic logic [31:0] packModel();
        logic [31:0] p;
        for (int i = 0; i < 8; i++) p[i*4 +: 4] = mMem[i];
        return p;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 8; i++) mMem[i] = 4'h0;
        mLoaded = 8'h00;
    endtask

    // Advance the model by one rising edge using the inputs that were applied.
    task automatic modelStep(input bit r, input bit v, input int a, input logic [3:0] d,
                             input bit s, input int sa, input bit c);
        bit acc;
        int tgt;
        if (r) begin
            modelClear();
            mMode = M_IDLE;
            mPtr = 0;
            mWritesLeft = 0;
            mJustReset = 1'b1;
        end else begin
            acc = v && modelReady();
            tgt = (mMode == M_FILL) ? mPtr : a;
            if (c) modelClear();
            else if (acc) begin
                mMem[tgt] = d;
                mLoaded[tgt] = 1'b1;
            end
            case (mMode)
                M_IDLE: if (s) begin
                    mMode = M_FILL;
                    mPtr = sa;
                    mWritesLeft = 8;
                end
                M_FILL: if (acc && !c) begin
                    mPtr = (mPtr + 1) % 8;
                    mWritesLeft = mWritesLeft - 1;
                    if (mWritesLeft == 0) mMode = M_DONE;
                end
                default: mMode = M_IDLE;
            endcase
            mJustReset = 1'b0;
        end
    endtask

    // Compare every output against the model.
    task automatic compareAll();
        logic [7:0] expPar;
        checkOutput("dout", packDut(), packModel());
        checkOutput("loaded", 32'(loaded), 32'(mLoaded));
        checkOutput("busy", 32'(busy), 32'(mMode == M_FILL));
        checkOutput("done", 32'(done), 32'(mMode == M_DONE));
        checkOutput("wr_ready", 32'(wrReady), 32'(modelReady()));
`ifdef DEMUX_PARITY_EN
        for (int i = 0; i < 8; i++) expPar[i] = ^mMem[i];
        checkOutput("parity", 32'(parity), 32'(expPar));
`else
        expPar = 8'h00;
`endif
        if (done === 1'b1) donePulses++;
    endtask

    // Drive one cycle of inputs, clock it, update the model, then check on the falling edge.
    task automatic applyStimulus(input bit r, input bit v, input int a, input logic [3:0] d,
                                 input bit s, input int sa, input bit c);
        rst = r;
        wrValid = v;
        addr = 3'(a);
        din = d;
        start = s;
        startAddr = 3'(sa);
        clr = c;
        @(posedge clk);
        modelStep(r, v, a, d, s, sa, c);
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 4'h0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mMem[i] = 4'h0;
        @(negedge clk);

        // Reset for two cycles, then ready appears on the second cycle after release.
        applyStimulus(1, 0, 0, 4'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0, 0, 0, 0);
        checkOutput("rst_loaded", 32'(loaded), 32'h0);
        checkOutput("rst_ready", 32'(wrReady), 32'h0);
        idleCycle();
        checkOutput("ready_after_rst", 32'(wrReady), 32'h1);

        // Single addressed writes.
        applyStimulus(0, 1, 3, 4'hA, 0, 0, 0);
        checkOutput("single_dout3", 32'(dout[3]), 32'hA);
        applyStimulus(0, 1, 7, 4'h5, 0, 0, 0);
        checkOutput("single_dout7", 32'(dout[7]), 32'h5);
        checkOutput("single_loaded", 32'(loaded), 32'h88);

        // Burst starting at 6 with two idle gaps; wraps 7 -> 0.
        donePulses = 0;
        applyStimulus(0, 0, 0, 4'h0, 1, 6, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3 || k == 6) begin
                idleCycle();
                checkOutput("burst_gap_busy", 32'(busy), 32'h1);
            end
            applyStimulus(0, 1, 0, 4'(k), 0, 0, 0);
        end
        checkOutput("burst_done", 32'(done), 32'h1);
        checkOutput("burst_done_ready", 32'(wrReady), 32'h0);
        idleCycle();
        checkOutput("burst_done_pulses", 32'(donePulses), 32'h1);
        checkOutput("burst_contents", packDut(), 32'h21876543);
        checkOutput("burst_loaded", 32'(loaded), 32'hFF);

        // Clear colliding with a write: clear wins.
        applyStimulus(0, 1, 2, 4'hF, 0, 0, 1);
        checkOutput("clr_dout2", 32'(dout[2]), 32'h0);
        checkOutput("clr_loaded", 32'(loaded), 32'h0);

        // Reset mid-burst abandons the burst without a done pulse.
        donePulses = 0;
        applyStimulus(0, 0, 0, 4'h0, 1, 0, 0);
        applyStimulus(0, 1, 0, 4'h9, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'hA, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'hB, 0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0, 0, 0, 0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_dout", packDut(), 32'h0);
        idleCycle();
        idleCycle();
        applyStimulus(0, 0, 0, 4'h0, 1, 5, 0);
        applyStimulus(0, 1, 1, 4'hC, 0, 0, 0);
        checkOutput("midrst_newstart", 32'(dout[5]), 32'hC);
        checkOutput("midrst_no_done", 32'(donePulses), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(99) == 0), ($urandom_range(9) < 6),
                          int'($urandom_range(7)), 4'($urandom_range(15)),
                          ($urandom_range(9) == 0), int'($urandom_range(7)),
                          ($urandom_range(19) == 0));
        end

`ifdef DEMUX_PARITY_EN
        // Parity of written entries and its clear.
        applyStimulus(1, 0, 0, 4'h0, 0, 0, 0);
        idleCycle();
        applyStimulus(0, 1, 1, 4'b0111, 0, 0, 0);
        applyStimulus(0, 1, 2, 4'b0011, 0, 0, 0);
        checkOutput("parity1", 32'(parity[1]), 32'h1);
        checkOutput("parity2", 32'(parity[2]), 32'h0);
        applyStimulus(0, 0, 0, 4'h0, 0, 0, 1);
        checkOutput("parity_clr", 32'(parity), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1to8_bank.md
Name: demux1to8_bank

Overview:
- Write-side counterpart of the team's 8-way 4-bit read mux: routes one 4-bit input to one of eight registered 4-bit outputs, dout0..dout7.
- The selected output holds its value until overwritten, and an 8:1 read mux can select across the outputs.
- Supports single addressed writes and an auto-incrementing 8-entry burst fill, with a valid/ready handshake and per-entry loaded flags.

Parameters:
- WIDTH, 4, data width of din and of each dout entry.
- DEPTH, 8, number of entries; fixed at 8; addr width is 3.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request; din/addr are valid while high.
- wr_ready  output  1  block can accept a write this cycle.
- addr  input  3  target entry for a single write; ignored during a burst.
- din  input  WIDTH  write data.
- start  input  1  one-cycle pulse; begins an 8-write burst fill.
- start_addr  input  3  first entry written by the burst.
- dout0..dout7  output  WIDTH each  registered entry contents.
- loaded  output  8  bit i set once entry i has been written since reset/clear.
- clr  input  1  synchronous clear of all entries and loaded flags.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the 8th burst write.

Behaviour:
- Reset (rst=1 at a clock edge): all doutN=0, loaded=0, busy=0, done=0, wr_ready=0, state=IDLE, ptr=0, cnt=0. rst has priority over every other input.
- Handshake: a write is accepted when wr_valid && wr_ready at a rising edge. The entry updates on that edge, so the new value is visible on doutN one cycle after acceptance (latency 1). wr_ready never depends combinationally on wr_valid.
- wr_ready is 1 in IDLE and FILL, and 0 in DONE and in the cycle following reset.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - An accepted write stores din into entry addr and sets loaded[addr].
  - start=1 latches ptr=start_addr and cnt=0, then goes to FILL. If start and an accepted write occur in the same cycle, the write is performed at addr and the burst still starts.
- FILL (busy=1):
  - Each accepted write stores din into entry ptr, sets loaded[ptr], sets ptr=ptr+1 mod 8 (wrapping 7 to 0), and sets cnt=cnt+1.
  - Cycles with wr_valid=0 are idle cycles; no timeout.
  - On the 8th accepted write (cnt==7), go to DONE.
  - start during FILL is ignored.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally return to IDLE.
- clr:
  - In any state, clr=1 zeroes all entries and loaded.
  - A write accepted in the same cycle is discarded; clr wins.
  - clr does not change FSM state, ptr or cnt. A burst in progress continues and its remaining writes land normally.
- Reset mid-burst: the burst is abandoned with no done pulse, and all state returns to reset values.
- Outputs are driven only from registers; there is no combinational path from inputs to doutN.
- Entries not addressed by a write hold their value.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- When defined:
  - Adds output parity[7:0]. parity[i] is the registered even-parity bit (XOR of all WIDTH bits) of entry i, updated on the same edge as the entry.
  - parity is cleared to 0 on rst and on clr.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - typedef state_t enum {IDLE, FILL, DONE};
  - localparam DEPTH=8 and ADDR_W=3;
  - typedef entry_t logic [WIDTH-1:0].
- One natural sub-module, wr_decoder3to8: combinational decoder producing an 8-bit one-hot write-enable from (sel, en). The top level feeds it addr in IDLE and ptr in FILL.

Test Plan:
- Reset then idle: rst high for 2 cycles -> all doutN=0, loaded=8'h00, busy=0, done=0; wr_ready=1 from the 2nd cycle after rst falls.
- Single writes: write din=4'hA to addr=3, then din=4'h5 to addr=7 -> dout3=A and dout7=5 one cycle after each acceptance, loaded=8'h88, other entries 0.
- Burst with wrap: start with start_addr=6, then 8 writes din=1..8 with 2 idle gaps -> dout6=1, dout7=2, dout0=3 ... dout5=8; busy high throughout; done pulses once; loaded=8'hFF.
- Clear collision: in IDLE, assert clr with wr_valid=1, addr=2, din=F -> dout2=0 and loaded=0 on the next cycle.
- Reset mid-burst: start at 0, 3 writes, then rst -> no done pulse; all outputs 0; state IDLE; a new start begins at the new start_addr.
- (DEMUX_PARITY_EN) Write 4'b0111 to entry 1 and 4'b0011 to entry 2 -> parity[1]=1, parity[2]=0; clr -> parity=8'h00.
